// File: rtl/detector_jogada_if.sv
// rtl/detector_jogada_if.sv - player-move bus between the game control unit and the move detector
interface detector_jogada_if;
    logic       habilitar;
    logic       limpar;
    logic [3:0] chaves;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       jogada_invalida;
    logic       timeout;
    logic [3:0] db_estado;

    modport master (
        output habilitar, limpar, chaves,
        input  jogada, jogada_feita, jogada_invalida, timeout, db_estado
    );

    modport slave (
        input  habilitar, limpar, chaves,
        output jogada, jogada_feita, jogada_invalida, timeout, db_estado
    );
endinterface

// File: rtl/detector_jogada.sv
// rtl/detector_jogada.sv - synchronises/debounces the switch bank, registers one move per press, runs the move timeout
module detector_jogada #(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int TIMEOUT_CYCLES  = 3000
) (
    input  logic              clock,
    input  logic              reset,
    detector_jogada_if.slave  io_jogo
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_OCIOSO        = 3'd0,
        S_ESPERA        = 3'd1,
        S_FILTRA        = 3'd2,
        S_REGISTRA      = 3'd3,
        S_ESPERA_SOLTAR = 3'd4,
        S_TIMEOUT       = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_sync1;
    logic [3:0]       r_chaves_s;
    logic [3:0]       r_sample;
    logic [3:0]       w_sample_nx;
    logic [DEB_W-1:0] r_deb;
    logic [DEB_W-1:0] w_deb_nx;
    logic [TMO_W-1:0] r_tmo;
    logic [TMO_W-1:0] w_tmo_nx;
    logic [TMO_W-1:0] w_tmo_inc;
    logic [3:0]       r_jogada;
    logic [3:0]       w_jogada_nx;
    logic             w_press;
    logic             w_onehot;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1    <= 4'd0;
            r_chaves_s <= 4'd0;
        end else begin
            r_sync1    <= io_jogo.chaves;
            r_chaves_s <= r_sync1;
        end
    end

    assign w_press   = (r_chaves_s != 4'd0);
    // Saturates so a glitch back from FILTRA after expiry still times out in ESPERA.
    assign w_tmo_inc = (r_tmo < TMO_MAX) ? (r_tmo + TMO_ONE) : r_tmo;

    always_comb begin
        w_next      = r_state;
        w_sample_nx = r_sample;
        w_deb_nx    = r_deb;
        w_tmo_nx    = r_tmo;
        w_jogada_nx = r_jogada;

        case (r_state)
            S_OCIOSO: begin
                if (io_jogo.habilitar) begin
                    w_next   = S_ESPERA;
                    w_tmo_nx = '0;
                end
            end
            S_ESPERA: begin
                w_tmo_nx = w_tmo_inc;
                if (w_press) begin
                    w_next      = S_FILTRA;
                    w_sample_nx = r_chaves_s;
                    w_deb_nx    = DEB_ONE;
                end else if (r_tmo >= TMO_LAST) begin
                    w_next = S_TIMEOUT;
                end
            end
            S_FILTRA: begin
                w_tmo_nx = w_tmo_inc;
                if (!w_press) begin
                    w_next = S_ESPERA;
                end else if (r_chaves_s != r_sample) begin
                    w_sample_nx = r_chaves_s;
                    w_deb_nx    = DEB_ONE;
                end else if (r_deb == DEB_LAST) begin
                    w_next = S_REGISTRA;
                end else if (r_tmo == TMO_LAST) begin
                    // Exact match: a press arriving on the expiry cycle enters here already past it.
                    w_next = S_TIMEOUT;
                end else begin
                    w_deb_nx = r_deb + DEB_ONE;
                end
            end
            S_REGISTRA: begin
                w_next   = S_ESPERA_SOLTAR;
                w_deb_nx = '0;
            end
            S_ESPERA_SOLTAR: begin
                if (w_press) begin
                    w_deb_nx = '0;
                end else if (r_deb == DEB_LAST) begin
                    w_next   = S_ESPERA;
                    w_tmo_nx = '0;
                end else begin
                    w_deb_nx = r_deb + DEB_ONE;
                end
            end
            S_TIMEOUT: begin
                if (io_jogo.limpar) begin
                    w_next   = S_ESPERA;
                    w_tmo_nx = '0;
                end
            end
            default: begin
                w_next = S_OCIOSO;
            end
        endcase

        if (io_jogo.limpar) begin
            w_tmo_nx = '0;
        end
        if (!io_jogo.habilitar && (r_state != S_REGISTRA)) begin
            w_next = S_OCIOSO;
        end
        // Load on entry so the code is valid together with the pulse.
        if (w_next == S_REGISTRA) begin
            w_jogada_nx = r_sample;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_OCIOSO;
            r_sample <= 4'd0;
            r_deb    <= '0;
            r_tmo    <= '0;
            r_jogada <= 4'd0;
        end else begin
            r_state  <= w_next;
            r_sample <= w_sample_nx;
            r_deb    <= w_deb_nx;
            r_tmo    <= w_tmo_nx;
            r_jogada <= w_jogada_nx;
        end
    end

    assign w_onehot = (r_sample != 4'd0) && ((r_sample & (r_sample - 4'd1)) == 4'd0);

    assign io_jogo.jogada          = r_jogada;
    assign io_jogo.jogada_feita    = (r_state == S_REGISTRA) && w_onehot;
    assign io_jogo.jogada_invalida = (r_state == S_REGISTRA) && !w_onehot;
    assign io_jogo.timeout         = (r_state == S_TIMEOUT);
    assign io_jogo.db_estado       = {1'b0, r_state};

endmodule

// File: tb/tb_detector_jogada.sv
// tb/tb_detector_jogada.sv - directed bench for detector_jogada with DEBOUNCE_CYCLES=3, TIMEOUT_CYCLES=20
module tb_detector_jogada;

    logic clock;
    logic reset;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_feita = 0;
    int   n_inval = 0;
    int   n_to    = 0;
    int   n_both  = 0;
    int   feita0;
    int   inval0;
    int   to0;

    detector_jogada_if u_if();

    detector_jogada #(
        .DEBOUNCE_CYCLES (3),
        .TIMEOUT_CYCLES  (20)
    ) u_dut (
        .clock   (clock),
        .reset   (reset),
        .io_jogo (u_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (u_if.jogada_feita)    n_feita++;
        if (u_if.jogada_invalida) n_inval++;
        if (u_if.timeout)         n_to++;
        if (u_if.jogada_feita && u_if.jogada_invalida) n_both++;
    endtask

    task automatic press(input logic [3:0] code, input int on_c, input int off_c);
        u_if.chaves = code;
        repeat (on_c) step();
        u_if.chaves = 4'd0;
        repeat (off_c) step();
    endtask

    initial begin
        reset          = 1'b0;
        u_if.habilitar = 1'b0;
        u_if.limpar    = 1'b0;
        u_if.chaves    = 4'd0;
        repeat (10) step();
        check_vec("rst_estado", 32'(u_if.db_estado), 32'd0);
        check_vec("rst_jogada", 32'(u_if.jogada), 32'd0);
        check_vec("rst_pulses", 32'({u_if.jogada_feita, u_if.jogada_invalida, u_if.timeout}), 32'd0);

        reset          = 1'b1;
        u_if.habilitar = 1'b1;
        step();
        check_vec("arm_espera", 32'(u_if.db_estado), 32'd1);

        // first press: edge n is the first sampling edge
        u_if.chaves = 4'b0001;
        step();
        step();
        check_vec("p1_n1_espera", 32'(u_if.db_estado), 32'd1);
        step();
        check_vec("p1_n2_filtra", 32'(u_if.db_estado), 32'd2);
        step();
        check_vec("p1_n3_nopulse", 32'(u_if.jogada_feita), 32'd0);
        step();
        check_vec("p1_n4_registra", 32'(u_if.db_estado), 32'd3);
        check_vec("p1_n4_feita", 32'(u_if.jogada_feita), 32'd1);
        check_vec("p1_n4_inval", 32'(u_if.jogada_invalida), 32'd0);
        check_vec("p1_jogada", 32'(u_if.jogada), 32'h1);
        u_if.chaves = 4'd0;
        step();
        check_vec("p1_n5_soltar", 32'(u_if.db_estado), 32'd4);
        check_vec("p1_n5_feita_low", 32'(u_if.jogada_feita), 32'd0);
        repeat (4) step();
        check_vec("p1_back_espera", 32'(u_if.db_estado), 32'd1);
        check_vec("p1_one_pulse", 32'(n_feita), 32'd1);
        check_vec("p1_timeout", 32'(u_if.timeout), 32'd0);

        // remaining one-hot codes
        press(4'b0010, 5, 5);
        check_vec("p2_jogada", 32'(u_if.jogada), 32'h2);
        press(4'b0100, 5, 5);
        check_vec("p3_jogada", 32'(u_if.jogada), 32'h4);
        press(4'b1000, 5, 5);
        check_vec("p4_jogada", 32'(u_if.jogada), 32'h8);
        check_vec("seq_pulses", 32'(n_feita), 32'd4);
        check_vec("seq_estado", 32'(u_if.db_estado), 32'd1);

        // 2-cycle glitch rejected, then an invalid two-hot press
        feita0 = n_feita;
        inval0 = n_inval;
        u_if.chaves = 4'b0100;
        step();
        step();
        u_if.chaves = 4'd0;
        step();
        check_vec("glitch_filtra", 32'(u_if.db_estado), 32'd2);
        repeat (3) step();
        check_vec("glitch_espera", 32'(u_if.db_estado), 32'd1);
        check_vec("glitch_nopulse", 32'(n_feita - feita0 + n_inval - inval0), 32'd0);
        press(4'b0110, 5, 5);
        check_vec("inval_pulse", 32'(n_inval - inval0), 32'd1);
        check_vec("inval_nofeita", 32'(n_feita - feita0), 32'd0);
        check_vec("inval_jogada", 32'(u_if.jogada), 32'h6);
        check_vec("inval_estado", 32'(u_if.db_estado), 32'd1);

        // timeout 20 cycles after entering ESPERA
        repeat (19) step();
        check_vec("to_pre_estado", 32'(u_if.db_estado), 32'd1);
        check_vec("to_pre_level", 32'(u_if.timeout), 32'd0);
        step();
        check_vec("to_estado", 32'(u_if.db_estado), 32'd5);
        check_vec("to_level", 32'(u_if.timeout), 32'd1);
        repeat (3) step();
        check_vec("to_held", 32'({u_if.timeout, u_if.db_estado}), 32'h15);
        u_if.limpar = 1'b1;
        step();
        u_if.limpar = 1'b0;
        check_vec("limpar_estado", 32'(u_if.db_estado), 32'd1);
        check_vec("limpar_level", 32'(u_if.timeout), 32'd0);

        // press seen on the exact expiry cycle
        to0    = n_to;
        feita0 = n_feita;
        repeat (17) step();
        u_if.chaves = 4'b0001;
        step();
        step();
        check_vec("exp_pre_espera", 32'(u_if.db_estado), 32'd1);
        step();
        check_vec("exp_press_wins", 32'(u_if.db_estado), 32'd2);
        step();
        step();
        u_if.chaves = 4'd0;
        repeat (5) step();
        check_vec("exp_no_timeout", 32'(n_to - to0), 32'd0);
        check_vec("exp_pulse", 32'(n_feita - feita0), 32'd1);
        check_vec("exp_estado", 32'(u_if.db_estado), 32'd1);

        // long hold: single pulse, no timeout while waiting for release
        to0    = n_to;
        feita0 = n_feita;
        u_if.chaves = 4'b0010;
        repeat (30) step();
        check_vec("long_soltar", 32'(u_if.db_estado), 32'd4);
        repeat (10) step();
        u_if.chaves = 4'd0;
        repeat (5) step();
        check_vec("long_espera", 32'(u_if.db_estado), 32'd1);
        check_vec("long_one_pulse", 32'(n_feita - feita0), 32'd1);
        check_vec("long_no_timeout", 32'(n_to - to0), 32'd0);
        repeat (19) step();
        check_vec("long_restart_pre", 32'(u_if.db_estado), 32'd1);
        step();
        check_vec("long_restart_to", 32'(u_if.db_estado), 32'd5);
        u_if.habilitar = 1'b0;
        step();
        check_vec("dis_from_to_estado", 32'(u_if.db_estado), 32'd0);
        check_vec("dis_from_to_level", 32'(u_if.timeout), 32'd0);
        u_if.habilitar = 1'b1;
        step();

        // habilitar low in ESPERA keeps jogada
        press(4'b1000, 5, 5);
        u_if.habilitar = 1'b0;
        step();
        check_vec("dis_estado", 32'(u_if.db_estado), 32'd0);
        check_vec("dis_jogada_hold", 32'(u_if.jogada), 32'h8);
        u_if.habilitar = 1'b1;
        step();
        check_vec("rearm_estado", 32'(u_if.db_estado), 32'd1);

        // asynchronous reset while filtering
        feita0 = n_feita;
        u_if.chaves = 4'b0001;
        repeat (3) step();
        check_vec("rf_filtra", 32'(u_if.db_estado), 32'd2);
        reset = 1'b0;
        #1;
        check_vec("rf_async_estado", 32'(u_if.db_estado), 32'd0);
        check_vec("rf_async_jogada", 32'(u_if.jogada), 32'd0);
        check_vec("rf_async_pulses", 32'({u_if.jogada_feita, u_if.jogada_invalida, u_if.timeout}), 32'd0);
        u_if.chaves = 4'd0;
        repeat (5) step();
        reset = 1'b1;
        step();
        check_vec("rf_rearm", 32'(u_if.db_estado), 32'd1);
        check_vec("rf_no_pulse", 32'(n_feita - feita0), 32'd0);
        check_vec("exclusive", 32'(n_both), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
